// File: rtl/mac_dot_seq_pkg.sv
// Shared types and width helpers for the dot-product sequencer and its MAC.
package mac_dot_seq_pkg;

  // Sequencer states; o_dbg_state carries the current one.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  // Accumulator width: full product plus guard bits.
  function automatic int calc_tbit(input int abit, input int bbit, input int ebit);
    return abit + bbit + ebit;
  endfunction

  // Operand index width, enough for indices 0..len_max-1.
  function automatic int calc_aw(input int len_max);
    return (len_max <= 2) ? 1 : $clog2(len_max);
  endfunction

  // Term-count width, enough to hold len_max itself.
  function automatic int calc_lw(input int len_max);
    return $clog2(len_max + 1);
  endfunction

endpackage

// File: rtl/mac_dot_seq_mac.sv
// Signed multiply-accumulate datapath. Each cycle the accumulator becomes
// (load ? loadVal : acc) +/- (useMul ? a*b : 0); with load=0 and useMul=0 it holds.
// Arithmetic wraps modulo 2^TBIT.
module MAC
  import mac_dot_seq_pkg::*;
#(
  parameter int ABIT = 8,
  parameter int BBIT = 8,
  parameter int EBIT = 8,
  localparam int TBIT = calc_tbit(ABIT, BBIT, EBIT)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic signed [TBIT-1:0] i_loadVal,
  input  logic                   i_useMul,
  input  logic                   i_add,
  input  logic signed [ABIT-1:0] i_a,
  input  logic signed [BBIT-1:0] i_b,
  output logic signed [TBIT-1:0] o_acc
);

  logic signed [ABIT+BBIT-1:0] w_prod;
  logic signed [TBIT-1:0]      w_prod_ext;
  logic signed [TBIT-1:0]      w_base;
  logic signed [TBIT-1:0]      w_term;
  logic signed [TBIT-1:0]      r_acc;

  // Full-precision signed product, sign-extended into the guard bits.
  assign w_prod     = i_a * i_b;
  assign w_prod_ext = TBIT'(w_prod);

  // Select the base (fresh load or running sum) and the signed term to add.
  always_comb begin
    w_base = i_load ? i_loadVal : r_acc;
    w_term = '0;
    if (i_useMul) begin
      w_term = i_add ? w_prod_ext : -w_prod_ext;
    end
  end

  // Accumulator register; the sum simply wraps on overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_base + w_term;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: fetches len operand pairs from a one-cycle-latency
// memory, steers the MAC, and publishes one registered result with a valid pulse.
//
// Job handshake: i_start is a request that is taken only on an edge where
// o_busy=0 and i_abort=0; o_busy acts as "not ready", so a request made while
// busy is dropped rather than queued. o_valid pulses once per completed job.
module mac_dot_seq
  import mac_dot_seq_pkg::*;
#(
  parameter int ABIT    = 8,
  parameter int BBIT    = 8,
  parameter int EBIT    = 8,
  parameter int LEN_MAX = 16,
  localparam int TBIT = calc_tbit(ABIT, BBIT, EBIT),
  localparam int AW   = calc_aw(LEN_MAX),
  localparam int LW   = calc_lw(LEN_MAX)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [LW-1:0]          i_len,
  input  logic signed [TBIT-1:0] i_init,
  input  logic                   i_sub,
  input  logic                   i_abort,
  output logic                   o_rd,
  output logic [AW-1:0]          o_addr,
  input  logic signed [ABIT-1:0] i_a,
  input  logic signed [BBIT-1:0] i_b,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic signed [TBIT-1:0] o_result,
  output state_t                 o_dbg_state
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [LW-1:0]          r_len;
  logic signed [TBIT-1:0] r_init;
  logic                   r_sub;
  logic                   r_rd;
  logic [AW-1:0]          r_addr;
  logic                   r_dv;
  logic                   r_first;
  logic                   r_valid;
  logic signed [TBIT-1:0] r_result;

  logic [LW-1:0]          w_len_clamped;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_capture;
  logic                   w_zero_load;
  logic                   w_mac_load;
  logic                   w_mac_mul;
  logic                   w_mac_add;
  logic signed [TBIT-1:0] w_acc;

  assign w_len_clamped = (i_len > LW'(LEN_MAX)) ? LW'(LEN_MAX) : i_len;
  // Abort beats a simultaneous start in IDLE.
  assign w_accept      = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_last        = (r_state == ST_FETCH) && (LW'(r_addr) == (r_len - LW'(1)));
  assign w_capture     = (r_state == ST_CAPTURE) && !i_abort;
  // An empty job still needs one cycle to copy init into the accumulator.
  assign w_zero_load   = (r_state == ST_DRAIN) && (r_len == '0);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort in any active state returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = (w_len_clamped == '0) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (i_abort) begin
          w_state_next = ST_IDLE;
        end else if (w_last) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_state_next = i_abort ? ST_IDLE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Latch the job parameters when a start is taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len  <= '0;
      r_init <= '0;
      r_sub  <= 1'b0;
    end else if (w_accept) begin
      r_len  <= w_len_clamped;
      r_init <= i_init;
      r_sub  <= i_sub;
    end
  end

  // Registered read strobe and index; index restarts at 0 and parks at 0 outside FETCH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd   <= 1'b0;
      r_addr <= '0;
    end else begin
      r_rd <= (w_state_next == ST_FETCH);
      if (w_state_next == ST_FETCH) begin
        r_addr <= (r_state == ST_FETCH) ? r_addr + AW'(1) : '0;
      end else begin
        r_addr <= '0;
      end
    end
  end

  // Memory-latency pipeline: data is on i_a/i_b the cycle after a read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dv    <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_dv    <= r_rd && !i_abort;
      r_first <= r_rd && (r_addr == '0);
    end
  end

  // Result register; only a non-aborted CAPTURE updates it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_result <= w_acc;
      end
    end
  end

  // First term reloads the accumulator from init; later terms accumulate.
  assign w_mac_load = (r_dv && r_first) || w_zero_load;
  assign w_mac_mul  = r_dv;
  assign w_mac_add  = !r_sub;

  MAC #(
    .ABIT (ABIT),
    .BBIT (BBIT),
    .EBIT (EBIT)
  ) u_mac (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_mac_load),
    .i_loadVal (r_init),
    .i_useMul  (w_mac_mul),
    .i_add     (w_mac_add),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_acc     (w_acc)
  );

  assign o_rd        = r_rd;
  assign o_addr      = r_addr;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_valid     = r_valid;
  assign o_result    = r_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq: memory model, scoreboard of expected
// results, read-trace and latency checks, plus an EBIT=0 instance for wrap.
module tb_mac_dot_seq;
  import mac_dot_seq_pkg::*;

  localparam int ABIT    = 8;
  localparam int BBIT    = 8;
  localparam int EBIT    = 8;
  localparam int LEN_MAX = 16;
  localparam int TBIT    = 24;
  localparam int TBIT0   = 16;
  localparam int AW      = 4;
  localparam int LW      = 5;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main instance signals
  logic                   start, sub, abort;
  logic [LW-1:0]          len;
  logic signed [TBIT-1:0] init;
  logic                   rd, busy, valid;
  logic [AW-1:0]          addr;
  logic signed [7:0]      a, b;
  logic signed [TBIT-1:0] result;
  state_t                 dbg_state;

  // EBIT=0 instance signals
  logic                    s_start, s_sub, s_abort;
  logic [LW-1:0]           s_len;
  logic signed [TBIT0-1:0] s_init;
  logic                    s_rd, s_busy, s_valid;
  logic [AW-1:0]           s_addr;
  logic signed [7:0]       s_a, s_b;
  logic signed [TBIT0-1:0] s_result;
  state_t                  s_dbg_state;

  mac_dot_seq #(.ABIT(ABIT), .BBIT(BBIT), .EBIT(EBIT), .LEN_MAX(LEN_MAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .i_init(init),
    .i_sub(sub), .i_abort(abort), .o_rd(rd), .o_addr(addr), .i_a(a), .i_b(b),
    .o_busy(busy), .o_valid(valid), .o_result(result), .o_dbg_state(dbg_state)
  );

  mac_dot_seq #(.ABIT(ABIT), .BBIT(BBIT), .EBIT(0), .LEN_MAX(LEN_MAX)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_len(s_len), .i_init(s_init),
    .i_sub(s_sub), .i_abort(s_abort), .o_rd(s_rd), .o_addr(s_addr), .i_a(s_a), .i_b(s_b),
    .o_busy(s_busy), .o_valid(s_valid), .o_result(s_result), .o_dbg_state(s_dbg_state)
  );

  // operand memory, synchronous read with one-cycle latency
  logic signed [7:0] mem_a[16];
  logic signed [7:0] mem_b[16];

  always @(posedge clk) begin
    if (rd) begin
      a <= mem_a[addr];
      b <= mem_b[addr];
    end
  end

  always @(posedge clk) begin
    if (s_rd) begin
      s_a <= mem_a[s_addr];
      s_b <= mem_b[s_addr];
    end
  end

  // bookkeeping
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;
  int e0 = 0;
  logic [AW-1:0]          rd_log[$];
  int                     rd_cyc[$];
  logic signed [TBIT-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // reference dot product, wrapped to w bits
  function automatic logic signed [63:0] model(input int n, input logic signed [63:0] ini,
                                               input bit sb, input int w);
    logic signed [63:0] acc, pa, pb;
    int m;
    m = (n > LEN_MAX) ? LEN_MAX : n;
    acc = ini;
    for (int k = 0; k < m; k++) begin
      pa = mem_a[k];
      pb = mem_b[k];
      acc = sb ? acc - pa * pb : acc + pa * pb;
    end
    acc = (acc <<< (64 - w)) >>> (64 - w);
    return acc;
  endfunction

  // monitor: read trace and scoreboard pop, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd) begin
        rd_log.push_back(addr);
        rd_cyc.push_back(cyc);
      end
      if (valid) begin
        valid_cnt++;
        valid_cyc = cyc;
        check("busy_low_in_valid", busy, 0);
        if (exp_q.size() == 0) check("valid_without_job", exp_q.size(), 1);
        else check("sb_result", result, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_job(input int n, input logic signed [TBIT-1:0] ini,
                           input bit sb, input bit expect_job);
    logic signed [63:0] m;
    start = 1'b1;
    len   = LW'(n);
    init  = ini;
    sub   = sb;
    if (expect_job) begin
      m = model(n, ini, sb, TBIT);
      exp_q.push_back(m[TBIT-1:0]);
    end
    @(posedge clk);
    #1;
    e0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int target, input int budget);
    int n;
    n = 0;
    while (valid_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (valid_cnt < target) check("valid_timeout", valid_cnt, target);
  endtask

  task automatic check_reads(input int n);
    check("rd_count", rd_log.size(), n);
    for (int i = 0; i < rd_log.size(); i++) begin
      check("rd_addr", rd_log[i], i);
      check("rd_cycle", rd_cyc[i], e0 + i);
    end
    rd_log.delete();
    rd_cyc.delete();
  endtask

  initial begin
    int va;
    int n;
    int s_e0;
    start = 0; sub = 0; abort = 0; len = '0; init = '0;
    s_start = 0; s_sub = 0; s_abort = 0; s_len = '0; s_init = '0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    rst_n = 1'b1;

    // reset state, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_rd", rd, 0);
    check("rst_addr", addr, 0);
    check("rst_result", result, 0);
    check("rst_state", dbg_state, ST_IDLE);
    step(2);
    rst_n = 1'b1;
    step(1);

    // len=3 add: 1*4+2*5+3*6 = 32
    mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3;
    mem_b[0] = 4; mem_b[1] = 5; mem_b[2] = 6;
    start_job(3, 0, 0, 1);
    check("t1_busy", busy, 1);
    wait_valid(1, 20);
    check("t1_latency", valid_cyc - e0, 5);
    check("t1_result", result, 32);
    check_reads(3);

    // len=2 subtract from 100: 100 - (-10 + -12) = 122
    mem_a[0] = -2; mem_a[1] = 3;
    mem_b[0] = 5;  mem_b[1] = -4;
    start_job(2, 100, 1, 1);
    wait_valid(2, 20);
    check("t2_latency", valid_cyc - e0, 4);
    check("t2_result", result, 122);
    check_reads(2);

    // abort after index 1 is issued
    start_job(5, 55, 0, 0);
    step(1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rd", rd, 0);
    step(8);
    check("abort_no_valid", valid_cnt, 2);
    check("abort_result_held", result, 122);
    check_reads(2);

    // abort together with start in IDLE: no job
    start = 1'b1; abort = 1'b1; len = 3;
    step(1);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 0);
    step(5);
    check("abort_start_no_valid", valid_cnt, 2);
    check("abort_start_no_rd", rd_log.size(), 0);

    // len=0 returns init
    start_job(0, -7, 0, 1);
    wait_valid(3, 20);
    check("len0_latency", valid_cyc - e0, 2);
    check("len0_result", result, -7);
    check_reads(0);

    // len=20 clamps to 16 reads
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'($urandom_range(0, 255));
      mem_b[i] = 8'($urandom_range(0, 255));
    end
    start_job(20, TBIT'($urandom_range(0, 4000)) - 24'sd2000, 1'($urandom_range(0, 1)), 1);
    wait_valid(4, 40);
    check("clamp_latency", valid_cyc - e0, 18);
    check_reads(16);

    // back-to-back: second start issued in the o_valid cycle
    start_job(2, 10, 0, 1);
    wait_valid(5, 20);
    va = valid_cyc;
    check_reads(2);
    start_job(3, -20, 1, 1);
    check("b2b_accept_edge", e0, va + 1);
    wait_valid(6, 20);
    check("b2b_latency", valid_cyc - e0, 5);
    check_reads(3);

    // start pulses while busy are dropped: 3 + 4*1 = 7
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 1;
      mem_b[i] = 1;
    end
    start_job(4, 3, 0, 1);
    step(1);
    start = 1'b1; init = 999; len = 1;
    step(1);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_valid(7, 20);
    check("busy_start_latency", valid_cyc - e0, 6);
    check("busy_start_result", result, 7);
    step(6);
    check("busy_start_single_valid", valid_cnt, 7);
    check("busy_start_sb_empty", exp_q.size(), 0);
    check_reads(4);

    // EBIT=0: (-128*-128)*2 wraps to -32768
    mem_a[0] = -128; mem_a[1] = -128;
    mem_b[0] = -128; mem_b[1] = -128;
    s_start = 1'b1; s_len = 2; s_init = 0; s_sub = 0;
    step(1);
    s_e0 = cyc;
    s_start = 1'b0;
    n = 0;
    while (!s_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wrap_valid_seen", s_valid, 1);
    check("wrap_latency", cyc - s_e0, 4);
    check("wrap_result", s_result, -32768);

    // asynchronous reset mid-FETCH
    start_job(6, 5, 0, 1);
    step(2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rd", rd, 0);
    check("midrst_addr", addr, 0);
    check("midrst_valid", valid, 0);
    check("midrst_result", result, 0);
    exp_q.delete();
    rd_log.delete();
    rd_cyc.delete();
    step(2);
    rst_n = 1'b1;
    step(4);
    check("post_rst_idle", busy, 0);
    check("post_rst_no_valid", valid_cnt, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
